gate_response_checker: RTL and testbench

- Synthesizable, clocked response checker for single-output logic gates. It is the receiving end of a gate stimulus sequence.
- It watches the input vector driven to a gate DUT and waits for each new vector to settle. It then compares the DUT output against a parameterized truth table, and accumulates error count, first-failure capture and input-space coverage.
- It sits beside any gate DUT in the logic-gate benches and on-board self-test wrappers, and produces a single pass/done verdict.

---
 rtl/gate_response_checker.sv | 147 ++++++++++++++
 tb/tb_gate_response_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// Response checker for a single-output gate: waits for each new input vector to settle,
// compares the DUT output against a truth table and accumulates errors and coverage.
module gate_response_checker #(
    parameter int unsigned          N_IN    = 2,
    parameter logic [2**N_IN-1:0]   GATE_TT = 4'b1000,
    parameter int unsigned          SETTLE  = 2,
    parameter int unsigned          ERR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [N_IN-1:0]      in_vec_i,
    input  logic                 dut_y_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_W-1:0]     err_count_o,
    output logic [2**N_IN-1:0]   cov_mask_o,
    output logic                 first_err_valid_o,
    output logic [N_IN-1:0]      first_err_vec_o,
    output logic                 first_err_y_o
);

    localparam int unsigned NVec       = 2**N_IN;
    localparam logic [3:0]  SettleLast = 4'(SETTLE - 1);

    typedef enum logic [2:0] {StIdle, StSettle, StCheck, StHold, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q;
    logic [3:0]        settle_cnt_q, settle_cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [NVec-1:0]   cov_q, cov_d;
    logic              fev_q, fev_d;
    logic [N_IN-1:0]   fevec_q, fevec_d;
    logic              fey_q, fey_d;
    logic              pass_q, pass_d;
    logic              change;
    logic              mismatch;
    logic              busy;

    assign change   = (in_vec_i != vec_q);
    assign mismatch = (dut_y_i != GATE_TT[vec_q]);
    assign busy     = (state_q == StSettle) || (state_q == StCheck) || (state_q == StHold);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        err_d        = err_q;
        cov_d        = cov_q;
        fev_d        = fev_q;
        fevec_d      = fevec_q;
        fey_d        = fey_q;
        pass_d       = pass_q;

        unique case (state_q)
            StIdle: ;
            StSettle: begin
                if (change) begin
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SettleLast) begin
                    settle_cnt_d = '0;
                    state_d      = StCheck;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            StCheck: begin
                cov_d[vec_q] = 1'b1;
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fev_q) begin
                        fev_d   = 1'b1;
                        fevec_d = vec_q;
                        fey_d   = dut_y_i;
                    end
                end
                state_d = StHold;
            end
            StHold: begin
                if (change) begin
                    settle_cnt_d = '0;
                    state_d      = StSettle;
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase

        // Stop overrides the FSM path but keeps any result update made in CHECK.
        if (stop_i && busy) begin
            state_d = StDone;
        end

        if ((state_d == StDone) && (state_q != StDone)) begin
            pass_d = (&cov_d) && (err_d == '0);
        end

        if (start_i) begin
            state_d      = StSettle;
            settle_cnt_d = '0;
            err_d        = '0;
            cov_d        = '0;
            fev_d        = 1'b0;
            fevec_d      = '0;
            fey_d        = 1'b0;
            pass_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vec_q        <= '0;
            settle_cnt_q <= '0;
            err_q        <= '0;
            cov_q        <= '0;
            fev_q        <= 1'b0;
            fevec_q      <= '0;
            fey_q        <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= in_vec_i;
            settle_cnt_q <= settle_cnt_d;
            err_q        <= err_d;
            cov_q        <= cov_d;
            fev_q        <= fev_d;
            fevec_q      <= fevec_d;
            fey_q        <= fey_d;
            pass_q       <= pass_d;
        end
    end

    assign busy_o            = busy;
    assign done_o            = (state_q == StDone);
    assign pass_o            = pass_q;
    assign err_count_o       = err_q;
    assign cov_mask_o        = cov_q;
    assign first_err_valid_o = fev_q;
    assign first_err_vec_o   = fevec_q;
    assign first_err_y_o     = fey_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: a 2-input AND checker and a 3-input XOR checker with a
// 2-bit error counter, driven by segment-level stimulus and compared to a result model.
module tb_gate_response_checker;

    localparam int unsigned S0 = 2;
    localparam int unsigned S1 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, stop0 = 1'b0, y0;
    logic [1:0] vec0   = '0;
    logic [3:0] fmask0 = '0;
    logic       busy0, done0, pass0, fev0, fey0;
    logic [7:0] err0;
    logic [3:0] cov0;
    logic [1:0] fvec0;

    logic       start1 = 1'b0, stop1 = 1'b0, y1;
    logic [2:0] vec1   = '0;
    logic [7:0] fmask1 = '0;
    logic       busy1, done1, pass1, fev1, fey1;
    logic [1:0] err1;
    logic [7:0] cov1;
    logic [2:0] fvec1;

    // Modelled gates: correct behaviour XOR a per-vector fault mask.
    assign y0 = (vec0 == 2'b11) ^ fmask0[vec0];
    assign y1 = (^vec1) ^ fmask1[vec1];

    gate_response_checker #(
        .N_IN(2), .GATE_TT(4'b1000), .SETTLE(S0), .ERR_W(8)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .stop_i(stop0), .in_vec_i(vec0),
        .dut_y_i(y0), .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_count_o(err0),
        .cov_mask_o(cov0), .first_err_valid_o(fev0), .first_err_vec_o(fvec0),
        .first_err_y_o(fey0)
    );

    gate_response_checker #(
        .N_IN(3), .GATE_TT(8'h96), .SETTLE(S1), .ERR_W(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .stop_i(stop1), .in_vec_i(vec1),
        .dut_y_i(y1), .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
        .cov_mask_o(cov1), .first_err_valid_o(fev1), .first_err_vec_o(fvec1),
        .first_err_y_o(fey1)
    );

    bit          sel = 1'b0;
    logic [31:0] o_busy, o_done, o_pass, o_err, o_cov, o_fev, o_fvec, o_fy;

    always_comb begin
        if (sel) begin
            o_busy = 32'(busy1); o_done = 32'(done1); o_pass = 32'(pass1);
            o_err  = 32'(err1);  o_cov  = 32'(cov1);  o_fev  = 32'(fev1);
            o_fvec = 32'(fvec1); o_fy   = 32'(fey1);
        end else begin
            o_busy = 32'(busy0); o_done = 32'(done0); o_pass = 32'(pass0);
            o_err  = 32'(err0);  o_cov  = 32'(cov0);  o_fev  = 32'(fev0);
            o_fvec = 32'(fvec0); o_fy   = 32'(fey0);
        end
    end

    int checks = 0;
    int errors = 0;
    int m_cov, m_err, m_fv, m_fvec, m_fy;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int settle_c();
        return sel ? S1 : S0;
    endfunction

    function automatic int nvec();
        return sel ? 8 : 4;
    endfunction

    function automatic int max_err();
        return sel ? 3 : 255;
    endfunction

    function automatic bit ref_y(input int v);
        logic [2:0] t;
        t = v[2:0];
        return sel ? ^t : (v == 3);
    endfunction

    function automatic bit fault_at(input int v);
        return sel ? fmask1[v] : fmask0[v];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_vec(input int v);
        if (sel) vec1 = 3'(v); else vec0 = 2'(v);
    endtask

    task automatic set_start(input bit b);
        if (sel) start1 = b; else start0 = b;
    endtask

    task automatic set_stop(input bit b);
        if (sel) stop1 = b; else stop0 = b;
    endtask

    task automatic m_clear();
        m_cov = 0; m_err = 0; m_fv = 0; m_fvec = 0; m_fy = 0;
    endtask

    // A vector held long enough is checked once; anything shorter leaves no trace.
    task automatic m_check(input int v);
        m_cov |= (1 << v);
        if (fault_at(v)) begin
            if (m_err < max_err()) m_err++;
            if (m_fv == 0) begin
                m_fv = 1; m_fvec = v; m_fy = int'(!ref_y(v));
            end
        end
    endtask

    // mode 0: plain segment, 1: start on first cycle, 2: start and stop together.
    task automatic seg(input int v, input int len, input int mode);
        set_vec(v);
        if (mode >= 1) begin
            set_start(1'b1);
            m_clear();
        end
        if (mode == 2) set_stop(1'b1);
        tick();
        set_start(1'b0);
        set_stop(1'b0);
        if (mode == 2) begin
            check_eq("ss_busy", o_busy, 1);
            check_eq("ss_done", o_done, 0);
            check_eq("ss_err", o_err, 0);
            check_eq("ss_cov", o_cov, 0);
            check_eq("ss_fev", o_fev, 0);
        end
        repeat (len - 1) tick();
        if (len >= settle_c() + 2) m_check(v);
    endtask

    task automatic finish_run(input string tag);
        int all;
        all = (1 << nvec()) - 1;
        set_stop(1'b1);
        tick();
        set_stop(1'b0);
        check_eq({tag, "_done"}, o_done, 1);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_err"}, o_err, 32'(m_err));
        check_eq({tag, "_cov"}, o_cov, 32'(m_cov));
        check_eq({tag, "_fev"}, o_fev, 32'(m_fv));
        if (m_fv != 0) begin
            check_eq({tag, "_fvec"}, o_fvec, 32'(m_fvec));
            check_eq({tag, "_fy"}, o_fy, 32'(m_fy));
        end
        check_eq({tag, "_pass"}, o_pass, 32'((m_cov == all) && (m_err == 0)));
        repeat (3) tick();
        check_eq({tag, "_hold"}, o_done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_done"}, o_done, 0);
        check_eq({tag, "_pass"}, o_pass, 0);
        check_eq({tag, "_err"}, o_err, 0);
        check_eq({tag, "_cov"}, o_cov, 0);
        check_eq({tag, "_fev"}, o_fev, 0);
        check_eq({tag, "_fvec"}, o_fvec, 0);
        check_eq({tag, "_fy"}, o_fy, 0);
    endtask

    initial begin
        int v, len, nseg;
        m_clear();
        repeat (2) tick();
        sel = 1'b0; #1 check_all_zero("rst0");
        sel = 1'b1; #1 check_all_zero("rst1");
        rst_n = 1'b1;
        tick();

        // Clean AND sweep with latency check on the first vector.
        sel = 1'b0; fmask0 = 4'b0000;
        set_vec(0); set_start(1'b1); m_clear();
        tick(); set_start(1'b0);
        tick(); tick();
        check_eq("lat_pre_cov", o_cov, 0);
        check_eq("lat_busy", o_busy, 1);
        tick();
        check_eq("lat_post_cov", o_cov, 1);
        tick();
        m_check(0);
        for (int i = 1; i < 4; i++) seg(i, 5, 0);
        finish_run("and_ok");

        // Output tied high.
        fmask0 = 4'b0111;
        seg(0, 5, 1);
        for (int i = 1; i < 4; i++) seg(i, 5, 0);
        finish_run("tied1");

        // Glitch then stable.
        fmask0 = 4'b0000;
        seg(1, 1, 1);
        seg(3, 6, 0);
        finish_run("glitch");

        // Long hold on a faulty vector.
        fmask0 = 4'b0100;
        seg(2, 100, 1);
        finish_run("hold100");

        // Saturation on the narrow counter.
        sel = 1'b1; fmask1 = 8'b0011_1110;
        seg(0, 6, 1);
        for (int i = 1; i < 8; i++) seg(i, 6, 0);
        finish_run("sat");

        // Asynchronous reset mid-run, then a clean sweep.
        sel = 1'b0; fmask0 = 4'b0000;
        seg(0, 5, 1);
        seg(3, 5, 0);
        rst_n = 1'b0;
        #1 check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        seg(0, 5, 1);
        for (int i = 1; i < 4; i++) seg(i, 5, 0);
        finish_run("postrst");

        // Start and stop together while holding.
        fmask0 = 4'b1111;
        seg(1, 6, 1);
        seg(2, 6, 0);
        seg(2, 6, 2);
        seg(0, 6, 0);
        finish_run("startstop");

        // Randomised runs on either checker.
        for (int r = 0; r < 40; r++) begin
            sel = 1'($urandom % 2);
            if ($urandom % 2 == 0) begin
                fmask0 = '0; fmask1 = '0;
            end else begin
                fmask0 = 4'($urandom); fmask1 = 8'($urandom);
            end
            nseg = 4 + int'($urandom % 10);
            v = int'($urandom % nvec());
            for (int s = 0; s < nseg; s++) begin
                if ($urandom % 4 == 0) len = 1 + int'($urandom % settle_c());
                else len = settle_c() + 2 + int'($urandom % 5);
                seg(v, len, (s == 0) ? 1 : 0);
                v = (v + 1 + int'($urandom % (nvec() - 1))) % nvec();
            end
            finish_run("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
